// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, timebase state encoding and functions bit indices for the PWM datapath
package pwm_pkg;
  localparam int CNT_W = 16;
  localparam int FUNC_W = 8;
  localparam int PSC_W = 8;
  localparam int FN_ALIGN_R = 0;
  localparam int FN_UNALIGNED = 1;
  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides the clock into count ticks, one every prescale_act+1 clocks while running
module pwm_prescaler import pwm_pkg::*; #(
  parameter int PSC_W = pwm_pkg::PSC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [PSC_W-1:0] prescale_act,
  output logic             tick
);
  logic [PSC_W-1:0] psc_cnt;
  // >= rather than == so a prescale shrunk while stopped cannot leave the divider running past its limit
  assign tick = run && (psc_cnt >= prescale_act);
  // divider holds when stopped and restarts from zero on clear
  always_ff @(posedge clk) begin
    if (rst || clear) psc_cnt <= '0;
    else if (run) psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
  end
endmodule

// File: rtl/pwm_timebase_ctrl.sv
// pwm_timebase_ctrl: run/stop timebase with double-buffered period, compares, functions and prescale
module pwm_timebase_ctrl import pwm_pkg::*; #(
  parameter int CNT_W = pwm_pkg::CNT_W,
  parameter int FUNC_W = pwm_pkg::FUNC_W,
  parameter int PSC_W = pwm_pkg::PSC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_en,
  input  logic              pwm_en_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [CNT_W-1:0]  compare1_i,
  input  logic [CNT_W-1:0]  compare2_i,
  input  logic [FUNC_W-1:0] functions_i,
  input  logic [PSC_W-1:0]  prescale_i,
  input  logic              cfg_load,
  input  logic              cnt_reset,
  output logic [CNT_W-1:0]  count_val,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  compare1,
  output logic [CNT_W-1:0]  compare2,
  output logic [FUNC_W-1:0] functions,
  output logic              pwm_en,
  output logic              wrap,
  output logic              load_pending
);
  state_t st;
  logic tick, at_top, commit;
  logic [CNT_W-1:0] period_sh, compare1_sh, compare2_sh;
  logic [FUNC_W-1:0] functions_sh;
  logic [PSC_W-1:0] prescale_sh, prescale_act;
  pwm_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk(clk),
    .rst(rst),
    .run(st == RUN),
    .clear(cnt_reset),
    .prescale_act(prescale_act),
    .tick(tick)
  );
  // >= lets a count left above a freshly shrunk period wrap on the next tick instead of overflowing
  assign at_top = count_val >= period;
  assign commit = load_pending && (cnt_reset || st == STOP || (tick && at_top));
  // FSM, counter, shadow capture and commit of active configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= STOP;
      count_val <= '0;
      period <= '0;
      compare1 <= '0;
      compare2 <= '0;
      functions <= '0;
      prescale_act <= '0;
      period_sh <= '0;
      compare1_sh <= '0;
      compare2_sh <= '0;
      functions_sh <= '0;
      prescale_sh <= '0;
      pwm_en <= 1'b0;
      wrap <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      st <= cnt_en ? RUN : STOP;
      pwm_en <= pwm_en_i && st == RUN;
      wrap <= !cnt_reset && tick && at_top;
      if (cnt_reset) count_val <= '0;
      else if (tick) count_val <= at_top ? '0 : count_val + 1'b1;
      if (cfg_load) begin
        period_sh <= period_i;
        compare1_sh <= compare1_i;
        compare2_sh <= compare2_i;
        functions_sh <= functions_i;
        prescale_sh <= prescale_i;
      end
      if (cnt_reset && cfg_load) begin
        period <= period_i;
        compare1 <= compare1_i;
        compare2 <= compare2_i;
        functions <= functions_i;
        prescale_act <= prescale_i;
      end else if (commit) begin
        period <= period_sh;
        compare1 <= compare1_sh;
        compare2 <= compare2_sh;
        functions <= functions_sh;
        prescale_act <= prescale_sh;
      end
      load_pending <= cfg_load ? !cnt_reset : (load_pending && !commit);
    end
  end
endmodule
